alu_seq: RTL and testbench

- Parametrised, registered successor to the team's combinational 4-bit ALU, keeping the same 8-operation set.
- Adds:
  - valid/ready handshakes on input and output;
  - a registered result with a status-flag bundle;
  - a multi-bit logical right shift that runs iteratively, one bit per cycle.
- Sits between the operand-fetch stage and the result writeback stage of the datapath.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered 8-op ALU with valid/ready handshakes and an iterative logical right shift
//
// Purpose:
//   Sits between operand fetch and result writeback. Accepts one operation per
//   handshake, computes it at WIDTH+1 bits, and holds the result and its flags
//   in output registers until the consumer takes them. SHR with a non-zero
//   amount runs one bit per cycle in the SHIFT state.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode valid
//   in_ready   block can accept an operation this cycle
//   op         000 ADD, 001 SUB, 010 INC, 011 DEC, 100 AND, 101 OR, 110 XOR, 111 SHR
//   a, b       operands (b[SHW-1:0] is the shift amount for SHR)
//   out_valid  result registers hold a valid result
//   out_ready  consumer takes the result
//   result     {carry/no-borrow, value}
//   zero       value == 0
//   neg        value msb
//   ovf        two's-complement overflow (arithmetic ops only)

module alu_seq #(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam logic [WIDTH:0] ONE_X  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] ONES_X = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [SHW-1:0]   cnt, cnt_nx;
    logic [SHW-1:0]   amt;
    logic             accept;

    logic [WIDTH:0]   alu_res;
    logic             alu_ovf;
    logic [WIDTH:0]   a_x, b_x, nb_x;

    logic             wr;
    logic [WIDTH:0]   wr_res;
    logic             wr_ovf;
    logic             out_valid_nx;

    assign amt = b[SHW-1:0];

    // Single-cycle datapath for every op. SHR only reaches the output through
    // this path when its amount is zero; non-zero amounts go through SHIFT.
    always_comb begin
        a_x     = {1'b0, a};
        b_x     = {1'b0, b};
        nb_x    = {1'b0, ~b};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = a_x + b_x;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a_x + nb_x + ONE_X;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_INC: begin
                alu_res = a_x + ONE_X;
                // Addend +1 is non-negative: overflow only crossing into the sign bit.
                alu_ovf = !a[WIDTH-1] && alu_res[WIDTH-1];
            end
            OP_DEC: begin
                alu_res = a_x + ONES_X;
                // Subtrahend +1 is non-negative: overflow only when the most
                // negative value wraps to positive.
                alu_ovf = a[WIDTH-1] && !alu_res[WIDTH-1];
            end
            OP_AND:  alu_res = {1'b0, a & b};
            OP_OR:   alu_res = {1'b0, a | b};
            OP_XOR:  alu_res = {1'b0, a ^ b};
            OP_SHR:  alu_res = {1'b0, a >> amt};
            default: alu_res = '0;
        endcase
    end

    // The slot is free when nothing is held or the held result leaves this cycle.
    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        work_nx  = work;
        cnt_nx   = cnt;
        wr       = 1'b0;
        wr_res   = alu_res;
        wr_ovf   = alu_ovf;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((op == OP_SHR) && (amt != '0)) begin
                        state_nx = SHIFT;
                        work_nx  = a;
                        cnt_nx   = amt;
                    end else begin
                        wr = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_nx = work >> 1;
                cnt_nx  = cnt - 1'b1;
                // The cycle with count==1 performs the last shift and publishes it.
                if (cnt == SHW'(1)) begin
                    wr       = 1'b1;
                    wr_res   = {1'b0, work >> 1};
                    wr_ovf   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A new write keeps out_valid high even when the old result drains now.
        out_valid_nx = wr ? 1'b1 : (out_ready ? 1'b0 : out_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nx;
            work      <= work_nx;
            cnt       <= cnt_nx;
            out_valid <= out_valid_nx;
            if (wr) begin
                result <= wr_res;
                zero   <= (wr_res[WIDTH-1:0] == '0);
                neg    <= wr_res[WIDTH-1];
                ovf    <= wr_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model

module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   result;
    logic         zero;
    logic         neg;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned and signed views of the operands.
    // Returns {ovf, neg, zero, result[4:0]}.
    function automatic logic [7:0] model(input int o, input int x, input int y);
        int r, sx, sy, t, carry, val;
        bit v;
        sx = (x > 7) ? x - 16 : x;
        sy = (y > 7) ? y - 16 : y;
        v  = 1'b0;
        r  = 0;
        t  = 0;
        case (o)
            0: begin r = x + y;            t = sx + sy; v = (t > 7) || (t < -8); end
            1: begin r = x + (15 - y) + 1; t = sx - sy; v = (t > 7) || (t < -8); end
            2: begin r = x + 1;            t = sx + 1;  v = (t > 7);             end
            3: begin r = x + 15;           t = sx - 1;  v = (t < -8);            end
            4: r = x & y;
            5: r = x | y;
            6: r = x ^ y;
            default: r = x >> (y % 4);
        endcase
        val   = r % 16;
        carry = (o < 4) ? (r / 16) % 2 : 0;
        return {v, 1'(val / 8), 1'(val == 0), 1'(carry), 4'(val)};
    endfunction

    function automatic int latency(input int o, input int y);
        return (o == 7 && (y % 4) != 0) ? (y % 4) + 1 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation with out_ready=1: checks latency, busy in_ready, result and flags.
    task automatic run_op(input int o, input int x, input int y);
        logic [7:0] e;
        int lat;
        int guard;
        e        = model(o, x, y);
        op       = 3'(o);
        a        = 4'(x);
        b        = 4'(y);
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("ready_before_op", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
        lat      = 1;
        while (!out_valid && lat < 20) begin
            check("busy_in_ready", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check($sformatf("lat op%0d a%0h b%0h", o, x, y), 32'(lat), 32'(latency(o, y)));
        check($sformatf("res op%0d a%0h b%0h", o, x, y), 32'(result), 32'(e[4:0]));
        check($sformatf("flg op%0d a%0h b%0h", o, x, y), 32'({ovf, neg, zero}), 32'(e[7:5]));
        tick();
        check("drained", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0] exp;
        int         due;
    } exp_t;

    initial begin
        exp_t q[$];
        int   cyc;
        int   idx;
        int   got;
        int   sa[8];
        int   sb[8];
        exp_t ex;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        a         = '0;
        b         = '0;

        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({ovf, neg, zero}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op(0, 4'b1011, 4'b1111);
        run_op(1, 4'b0011, 4'b0101);
        run_op(1, 4'b1000, 4'b0001);
        run_op(2, 4'b1111, 4'b0000);
        run_op(3, 4'b0000, 4'b0000);
        run_op(3, 4'b1000, 4'b0000);
        run_op(0, 4'b0111, 4'b0001);
        run_op(7, 4'b1011, 4'b0010);
        run_op(7, 4'b1011, 4'b0000);
        run_op(7, 4'b1111, 4'b0011);

        // Backpressure: held result stays stable, then drain and refill in one cycle
        out_ready = 1'b0;
        op = 3'b110; a = 4'b1100; b = 4'b1010; in_valid = 1'b1;
        tick();
        op = 3'b100;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(result), 32'b0_0110);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_new_valid", 32'(out_valid), 32'd1);
        check("bp_new_result", 32'(result), 32'b0_1000);
        check("bp_new_flags", 32'({ovf, neg, zero}), 32'b010);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset during a shift
        op = 3'b111; a = 4'b1111; b = 4'b0011; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid_shift_busy", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_flags", 32'({ovf, neg, zero}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_stale_valid", 32'(out_valid), 32'd0);
        end
        check("no_stale_result", 32'(result), 32'd0);

        // Random single operations
        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

        // Streaming: all opcodes back to back, out_ready held high
        for (int i = 0; i < 8; i++) begin
            sa[i] = int'($urandom_range(0, 15));
            sb[i] = int'($urandom_range(0, 15));
        end
        idx = 0;
        got = 0;
        cyc = 0;
        while ((idx < 8 || q.size() != 0) && cyc < 200) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("stream_extra", 32'd1, 32'd0);
                end else begin
                    ex = q.pop_front();
                    got++;
                    check("stream_due", 32'(cyc), 32'(ex.due));
                    check("stream_res", 32'(result), 32'(ex.exp[4:0]));
                    check("stream_flg", 32'({ovf, neg, zero}), 32'(ex.exp[7:5]));
                end
            end
            if (in_ready && idx < 8) begin
                op = 3'(idx); a = 4'(sa[idx]); b = 4'(sb[idx]); in_valid = 1'b1;
                ex.exp = model(idx, sa[idx], sb[idx]);
                ex.due = cyc + latency(idx, sb[idx]);
                q.push_back(ex);
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 32'(got), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
